// File: rtl/frame_req_pkg.sv
// Shared types and default widths for the frame-request sequencer and its timer.
package frame_req_pkg;

   localparam int unsigned FRAME_REQ_PERIOD_W   = 32;
   localparam int unsigned FRAME_REQ_COUNT_W    = 16;
   localparam int unsigned FRAME_REQ_MIN_PERIOD = 2;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWaitAck,
      StWaitPeriod
   } frame_req_state_t;

endpackage

// File: rtl/frame_req_timer.sv
// Loadable down-counter that holds at zero; expired is high whenever the count is zero.
module frame_req_timer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_expired
);

   logic [WIDTH-1:0] r_count;

   // Load wins over decrement so a reload on the final count is never lost.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - WIDTH'(1);
      end
   end

   assign o_expired = (r_count == '0);

endmodule

// File: rtl/frame_request_sequencer.sv
// Frame-request pulse generator (single/burst/continuous) with overrun detection.
// Defining FRAME_REQ_TIMEOUT_EN adds an acknowledge timeout driving timeout_err.
module frame_request_sequencer
   import frame_req_pkg::*;
#(
   parameter int unsigned PERIOD_W = FRAME_REQ_PERIOD_W,
   parameter int unsigned COUNT_W  = FRAME_REQ_COUNT_W
) (
   input  logic                x_clk,
   input  logic                x_rst,
   input  logic                enable,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [COUNT_W-1:0]  burst_count,
   input  logic [PERIOD_W-1:0] frame_period,
   input  logic [PERIOD_W-1:0] ack_timeout,
   input  logic                trigger_i,
   output logic                new_frame_x,
   output logic                busy,
   output logic                done,
   output logic [COUNT_W-1:0]  frames_issued,
   output logic                overrun,
   output logic                timeout_err
);

   frame_req_state_t r_state;
   frame_req_state_t w_state_next;

   logic                r_trig;
   logic                r_cont;
   logic                r_stop_pend;
   logic [COUNT_W-1:0]  r_burst;
   logic [COUNT_W-1:0]  r_frames;
   logic                r_new_frame;
   logic                r_busy;
   logic                r_done;
   logic                r_overrun;
   logic                r_timeout;

   logic                w_ack;
   logic                w_accept;
   logic                w_finish;
   logic                w_resolve;
   logic                w_expired;
   logic                w_timeout;
   logic                w_issue_next;
   logic                w_period_dec;
   logic [PERIOD_W-1:0] w_period_load;

   logic                w_new_frame_d;
   logic                w_busy_d;
   logic                w_done_d;
   logic                w_overrun_d;
   logic                w_timeout_d;
   logic [COUNT_W-1:0]  w_frames_d;

   // Exposure acknowledge is the falling edge of the trigger stage output.
   assign w_ack    = r_trig & ~trigger_i;
   assign w_accept = (r_state == StIdle) & start & enable & (continuous | (burst_count != '0));
   assign w_finish = r_stop_pend | (~r_cont & (r_frames == r_burst));

   assign w_issue_next  = (w_state_next == StIssue);
   assign w_period_dec  = (r_state != StIdle);
   assign w_period_load = (frame_period < PERIOD_W'(FRAME_REQ_MIN_PERIOD))
                          ? PERIOD_W'(FRAME_REQ_MIN_PERIOD - 1)
                          : frame_period - PERIOD_W'(1);

   // Loaded on entry to ISSUE so that pulse spacing equals the clamped period.
   frame_req_timer #(
      .WIDTH (PERIOD_W)
   ) u_period_timer (
      .i_clk      (x_clk),
      .i_rst      (x_rst),
      .i_load     (w_issue_next),
      .i_load_val (w_period_load),
      .i_dec      (w_period_dec),
      .o_expired  (w_expired)
   );

`ifdef FRAME_REQ_TIMEOUT_EN
   logic r_to_en;
   logic w_to_expired;
   logic w_to_dec;

   assign w_to_dec = (r_state == StIssue) | (r_state == StWaitAck);

   frame_req_timer #(
      .WIDTH (PERIOD_W)
   ) u_timeout_timer (
      .i_clk      (x_clk),
      .i_rst      (x_rst),
      .i_load     (w_issue_next),
      .i_load_val (ack_timeout),
      .i_dec      (w_to_dec),
      .o_expired  (w_to_expired)
   );

   // A zero timeout value leaves the timeout disarmed for that frame.
   always_ff @(posedge x_clk) begin
      if (x_rst) begin
         r_to_en <= 1'b0;
      end else if (w_issue_next) begin
         r_to_en <= (ack_timeout != '0);
      end
   end

   assign w_timeout = r_to_en & w_to_expired & (r_state == StWaitAck);
`else
   logic w_unused_ack_timeout;

   assign w_unused_ack_timeout = ^ack_timeout;
   assign w_timeout            = 1'b0;
`endif

   always_ff @(posedge x_clk) begin
      if (x_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_resolve    = 1'b0;
      if (!enable) begin
         w_state_next = StIdle;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  w_state_next = StIssue;
               end
            end
            StIssue: begin
               w_state_next = StWaitAck;
            end
            StWaitAck: begin
               if (w_ack) begin
                  if (w_expired) begin
                     w_resolve = 1'b1;
                  end else begin
                     w_state_next = StWaitPeriod;
                  end
               end else if (w_timeout) begin
                  w_state_next = StIdle;
               end
            end
            StWaitPeriod: begin
               if (w_expired) begin
                  w_resolve = 1'b1;
               end
            end
            default: begin
               w_state_next = StIdle;
            end
         endcase
         if (w_resolve) begin
            w_state_next = w_finish ? StIdle : StIssue;
         end
      end
   end

   always_comb begin
      w_new_frame_d = (w_state_next == StIssue);
      w_busy_d      = (w_state_next != StIdle);
      w_done_d      = w_resolve & w_finish;
      w_frames_d    = r_frames;
      w_overrun_d   = r_overrun;
      w_timeout_d   = r_timeout;
      if (w_accept) begin
         w_frames_d  = '0;
         w_overrun_d = 1'b0;
         w_timeout_d = 1'b0;
      end else if (enable) begin
         if ((r_state == StIssue) && (r_frames != '1)) begin
            w_frames_d = r_frames + COUNT_W'(1);
         end
         if ((r_state == StWaitAck) && w_expired && !w_ack) begin
            w_overrun_d = 1'b1;
         end
         if (w_timeout) begin
            w_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge x_clk) begin
      if (x_rst) begin
         r_trig      <= 1'b1;
         r_cont      <= 1'b0;
         r_burst     <= '0;
         r_stop_pend <= 1'b0;
         r_frames    <= '0;
         r_new_frame <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overrun   <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_trig      <= trigger_i;
         r_frames    <= w_frames_d;
         r_new_frame <= w_new_frame_d;
         r_busy      <= w_busy_d;
         r_done      <= w_done_d;
         r_overrun   <= w_overrun_d;
         r_timeout   <= w_timeout_d;
         if (w_accept) begin
            r_cont  <= continuous;
            r_burst <= burst_count;
         end
         // Stop only matters while a sequence is running; it never cuts a frame short.
         if (w_state_next == StIdle) begin
            r_stop_pend <= 1'b0;
         end else if (stop && (r_state != StIdle)) begin
            r_stop_pend <= 1'b1;
         end
      end
   end

   assign new_frame_x   = r_new_frame;
   assign busy          = r_busy;
   assign done          = r_done;
   assign frames_issued = r_frames;
   assign overrun       = r_overrun;
   assign timeout_err   = r_timeout;

endmodule

// File: tb/tb_frame_request_sequencer.sv
// Scoreboard bench for frame_request_sequencer: expected pulse/done events are queued at
// stimulus time and matched by a negedge monitor; direct checks cover status outputs.
module tb_frame_request_sequencer;

   localparam int EvPulse = 0;
   localparam int EvDone  = 1;

   logic        x_clk = 1'b0;
   logic        x_rst;
   logic        enable;
   logic        start;
   logic        stop;
   logic        continuous;
   logic [15:0] burst_count;
   logic [31:0] frame_period;
   logic [31:0] ack_timeout;
   logic        trigger_i;
   logic        new_frame_x;
   logic        busy;
   logic        done;
   logic [15:0] frames_issued;
   logic        overrun;
   logic        timeout_err;

   typedef struct {
      int kind;
      int cyc;
      int frames;
      int ovr;
      bit chk;
   } ev_t;

   ev_t sb[$];
   int  n_tests = 0;
   int  n_fail  = 0;
   int  cyc     = 0;
   int  trig_d  = 0;
   int  c;

   frame_request_sequencer #(
      .PERIOD_W (32),
      .COUNT_W  (16)
   ) dut (
      .x_clk         (x_clk),
      .x_rst         (x_rst),
      .enable        (enable),
      .start         (start),
      .stop          (stop),
      .continuous    (continuous),
      .burst_count   (burst_count),
      .frame_period  (frame_period),
      .ack_timeout   (ack_timeout),
      .trigger_i     (trigger_i),
      .new_frame_x   (new_frame_x),
      .busy          (busy),
      .done          (done),
      .frames_issued (frames_issued),
      .overrun       (overrun),
      .timeout_err   (timeout_err)
   );

   always #5 x_clk = ~x_clk;

   always @(posedge x_clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic exp_ev(input int kind, input int at, input int frames, input int ovr,
                         input bit chk);
      ev_t e;
      e.kind   = kind;
      e.cyc    = at;
      e.frames = frames;
      e.ovr    = ovr;
      e.chk    = chk;
      sb.push_back(e);
   endtask

   task automatic sb_check(input int kind);
      ev_t e;
      if (sb.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
      end else begin
         e = sb.pop_front();
         check("event_kind", kind, e.kind);
         check("event_cycle", cyc, e.cyc);
         if (e.chk) begin
            check("event_frames", 32'(frames_issued), e.frames);
            check("event_overrun", 32'(overrun), e.ovr);
         end
      end
   endtask

   // Monitor: every pulse or done must match the head of the expectation queue.
   always @(negedge x_clk) begin
      if (new_frame_x === 1'b1) sb_check(EvPulse);
      if (done === 1'b1) sb_check(EvDone);
   end

   // Trigger stage model: trigger_i low for one cycle, trig_d cycles after each pulse.
   initial begin
      trigger_i = 1'b1;
      forever begin
         @(negedge x_clk);
         if ((new_frame_x === 1'b1) && (trig_d > 0)) begin
            repeat (trig_d) @(posedge x_clk);
            #1 trigger_i = 1'b0;
            @(posedge x_clk);
            #1 trigger_i = 1'b1;
         end
      end
   end

   task automatic wait_to(input int target);
      while (cyc < target) begin
         @(posedge x_clk);
         #1;
      end
   endtask

   // Start is driven during cycle c and sampled at the following edge.
   task automatic start_seq(input logic cont, input int burst, input int period, input int d,
                            output int c0);
      @(posedge x_clk);
      #1;
      c0           = cyc;
      continuous   = cont;
      burst_count  = 16'(burst);
      frame_period = 32'(period);
      trig_d       = d;
      start        = 1'b1;
      @(posedge x_clk);
      #1;
      start = 1'b0;
   endtask

   initial begin
      x_rst        = 1'b1;
      enable       = 1'b1;
      start        = 1'b0;
      stop         = 1'b0;
      continuous   = 1'b0;
      burst_count  = '0;
      frame_period = '0;
      ack_timeout  = 32'd30;

      // Reset state
      repeat (3) @(posedge x_clk);
      #1;
      check("rst_new_frame", 32'(new_frame_x), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_frames", 32'(frames_issued), 0);
      check("rst_overrun", 32'(overrun), 0);
      check("rst_timeout", 32'(timeout_err), 0);
      x_rst = 1'b0;

      // Burst of 3 at period 100, ack 10 cycles after each pulse
      start_seq(1'b0, 3, 100, 10, c);
      check("burst_busy", 32'(busy), 1);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 101, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 201, 0, 0, 1'b0);
      exp_ev(EvDone, c + 301, 3, 0, 1'b1);
      wait_to(c + 310);
      check("burst_idle", 32'(busy), 0);
      check("burst_frames", 32'(frames_issued), 3);

      // Continuous at period 50, stop 20 cycles after the 4th pulse
      start_seq(1'b1, 0, 50, 10, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 51, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 101, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 151, 0, 0, 1'b0);
      exp_ev(EvDone, c + 201, 4, 0, 1'b1);
      wait_to(c + 171);
      stop = 1'b1;
      @(posedge x_clk);
      #1;
      stop = 1'b0;
      wait_to(c + 200);
      check("cont_busy_before_done", 32'(busy), 1);
      wait_to(c + 260);
      check("cont_idle", 32'(busy), 0);
      continuous = 1'b0;

      // Overrun: period 20, ack 35 cycles after each pulse
      start_seq(1'b0, 2, 20, 35, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 37, 0, 0, 1'b0);
      exp_ev(EvDone, c + 73, 2, 1, 1'b1);
      wait_to(c + 20);
      check("ovr_not_yet", 32'(overrun), 0);
      wait_to(c + 21);
      check("ovr_set", 32'(overrun), 1);
      wait_to(c + 80);
      check("ovr_sticky", 32'(overrun), 1);
      check("ovr_no_timeout", 32'(timeout_err), 0);

      // Abort by enable low in WAIT_PERIOD
      start_seq(1'b0, 5, 40, 5, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 41, 0, 0, 1'b0);
      wait_to(c + 60);
      enable = 1'b0;
      wait_to(c + 61);
      check("abort_idle", 32'(busy), 0);
      check("abort_frames", 32'(frames_issued), 2);
      check("abort_ovr_cleared", 32'(overrun), 0);
      enable = 1'b1;
      wait_to(c + 160);
      check("abort_stays_idle", 32'(busy), 0);

      // frame_period = 0 clamps to spacing of 2
      start_seq(1'b0, 4, 0, 1, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 3, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 5, 0, 0, 1'b0);
      exp_ev(EvPulse, c + 7, 0, 0, 1'b0);
      exp_ev(EvDone, c + 9, 4, 0, 1'b1);
      wait_to(c + 20);

      // burst_count = 0 without continuous: start ignored
      start_seq(1'b0, 0, 10, 0, c);
      check("zero_burst_busy", 32'(busy), 0);
      wait_to(c + 5);
      check("zero_burst_busy_later", 32'(busy), 0);
      check("zero_burst_frames_held", 32'(frames_issued), 4);

`ifdef FRAME_REQ_TIMEOUT_EN
      // Ack timeout of 30 with trigger held high
      ack_timeout = 32'd30;
      start_seq(1'b0, 2, 100, 0, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      wait_to(c + 31);
      check("to_busy_before", 32'(busy), 1);
      check("to_err_before", 32'(timeout_err), 0);
      wait_to(c + 32);
      check("to_idle", 32'(busy), 0);
      check("to_err", 32'(timeout_err), 1);
      wait_to(c + 150);
`else
      check("timeout_tied_low", 32'(timeout_err), 0);
`endif

      // Reset in the middle of a burst
      start_seq(1'b0, 3, 30, 5, c);
      exp_ev(EvPulse, c + 1, 0, 0, 1'b0);
      wait_to(c + 10);
      check("midrst_busy_before", 32'(busy), 1);
      x_rst = 1'b1;
      wait_to(c + 11);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_frames", 32'(frames_issued), 0);
      check("midrst_new_frame", 32'(new_frame_x), 0);
      check("midrst_done", 32'(done), 0);
      check("midrst_overrun", 32'(overrun), 0);
      check("midrst_timeout", 32'(timeout_err), 0);
      x_rst = 1'b0;
      wait_to(c + 80);
      check("midrst_stays_idle", 32'(busy), 0);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
